// File: rtl/pixel_stream_feeder_if.sv
// Pixel stream from the frame-buffer feeder to the classifier's data_in port.
// The master drives pixel data and frame markers; the slave returns ready.
interface pixel_stream_feeder_if #(
    parameter int unsigned PIX_W = 24
) ();
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_sof;
    logic             pix_eol;
    logic             pix_eof;

    modport master (
        output pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/pixel_stream_feeder.sv
// Reads one frame from a synchronous-read frame buffer in raster order, streams it out with
// frame markers over valid/ready, then waits for the classifier result or times out.
module pixel_stream_feeder #(
    parameter int unsigned IMG_W   = 128,
    parameter int unsigned IMG_H   = 128,
    parameter int unsigned PIX_W   = 24,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic                 mem_rd_en_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    input  logic [PIX_W-1:0]     mem_rd_data_i,
    pixel_stream_feeder_if.master pix,
    input  logic                 res_valid_i,
    input  logic [7:0]           res_class_i,
    output logic [7:0]           class_out_o
);
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(NPIX + 1);
    localparam int unsigned X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic             rd_pend_q;
    logic [TMO_W-1:0] tmo_q;
    logic             busy_q, done_q, timeout_q;
    logic [7:0]       class_q;

    logic [PIX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic             head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             sof_q, eol_q, eof_q;

    logic             pop_c, accept_c, last_hs_c, rd_en_c;
    logic [1:0]       occ_c;

    // The head entry being handshaken this cycle frees its slot for a new read,
    // which keeps one pixel per cycle flowing with only two slots.
    assign pop_c     = head_vld_q & pix.pix_ready;
    assign accept_c  = (state_q == S_IDLE) & start_i;
    assign last_hs_c = pop_c & eof_q;
    assign occ_c     = 2'(head_vld_q) + 2'(tail_vld_q) + 2'(rd_pend_q) - 2'(pop_c);
    assign rd_en_c   = !rst && (state_q == S_STREAM) && (rd_cnt_q < CNT_W'(NPIX))
                       && (occ_c < 2'd2);

    assign mem_rd_en_o   = rd_en_c;
    assign mem_addr_o    = ADDR_W'(rd_cnt_q);
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign class_out_o   = class_q;
    assign pix.pix_data  = head_q;
    assign pix.pix_valid = head_vld_q;
    assign pix.pix_sof   = sof_q;
    assign pix.pix_eol   = eol_q;
    assign pix.pix_eof   = eof_q;

    // Control FSM, read counter and result/timeout handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            class_q   <= 8'h00;
        end else begin
            done_q    <= 1'b0;
            rd_pend_q <= rd_en_c;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q   <= S_STREAM;
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                        rd_cnt_q  <= '0;
                    end
                end
                S_STREAM: begin
                    if (rd_en_c) begin
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                    end
                    if (last_hs_c) begin
                        state_q <= S_WAIT;
                        tmo_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (res_valid_i) begin
                        class_q   <= res_class_i;
                        timeout_q <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        class_q   <= 8'hFF;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Two-entry output FIFO: returned read data lands in head if empty, else in tail.
    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        tail_d     = tail_q;
        tail_vld_d = tail_vld_q;
        if (pop_c) begin
            if (tail_vld_q) begin
                head_d     = tail_q;
                tail_vld_d = rd_pend_q;
                if (rd_pend_q) tail_d = mem_rd_data_i;
            end else begin
                head_vld_d = rd_pend_q;
                if (rd_pend_q) head_d = mem_rd_data_i;
            end
        end else if (rd_pend_q) begin
            if (!head_vld_q) begin
                head_d     = mem_rd_data_i;
                head_vld_d = 1'b1;
            end else begin
                tail_d     = mem_rd_data_i;
                tail_vld_d = 1'b1;
            end
        end
    end

    // Raster position of the head pixel; advances on each handshake.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept_c) begin
            x_d = '0;
            y_d = '0;
        end else if (pop_c) begin
            if (x_q == X_W'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (y_q == Y_W'(IMG_H - 1)) ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sof_q      <= head_vld_d && (x_d == '0) && (y_d == '0);
            eol_q      <= head_vld_d && (x_d == X_W'(IMG_W - 1));
            eof_q      <= head_vld_d && (x_d == X_W'(IMG_W - 1)) && (y_d == Y_W'(IMG_H - 1));
        end
    end
endmodule
